// File: rtl/sym_packer.sv
// sym_packer: packs 2-bit FSM output symbols into 2*SYMS-bit words.
// Completed words go through a 2-entry FIFO to a valid/ready consumer.
// The block also keeps a saturating count of MATCH symbols and a sticky
// overflow flag for words lost when the FIFO was full.
module sym_packer #(
  parameter int unsigned SYMS  = 4,
  parameter logic [1:0]  MATCH = 2'b01,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sym_in,
  input  logic                  sym_en,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [2*SYMS-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            fill,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic                  ovf
);

  localparam int unsigned     W         = 2 * SYMS;
  localparam logic [3:0]      LAST_FILL = 4'(SYMS - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = '1;

  logic [W-1:0]     r_part;
  logic [3:0]       r_fill;
  logic [W-1:0]     r_q0;
  logic [W-1:0]     r_q1;
  logic [1:0]       r_cnt;
  logic             r_valid;
  logic [CNT_W-1:0] r_hit;
  logic             r_ovf;

  logic [W-1:0]     w_ins;
  logic             w_complete;
  logic             w_flush_push;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [W-1:0]     w_word;
  logic [W-1:0]     w_part_nxt;
  logic [3:0]       w_fill_nxt;
  logic [W-1:0]     w_q0_nxt;
  logic [W-1:0]     w_q1_nxt;
  logic [1:0]       w_cnt_nxt;

  // Place the incoming symbol at the current fill position of the partial word.
  always_comb begin
    w_ins = r_part;
    for (int i = 0; i < int'(SYMS); i++) begin
      if (r_fill == 4'(i)) begin
        w_ins[2*i +: 2] = sym_in;
      end
    end
  end

  // Word completion / flush decision; unused positions of r_part stay zero,
  // so the flushed word is already zero-padded.
  always_comb begin
    w_complete   = sym_en && (r_fill == LAST_FILL);
    w_flush_push = flush && (sym_en || (r_fill != 4'd0));
    w_push       = w_complete || w_flush_push;
    w_word       = sym_en ? w_ins : r_part;
    w_part_nxt   = r_part;
    w_fill_nxt   = r_fill;
    if (w_push) begin
      w_part_nxt = '0;
      w_fill_nxt = 4'd0;
    end else if (sym_en) begin
      w_part_nxt = w_ins;
      w_fill_nxt = r_fill + 4'd1;
    end
  end

  // Two-entry FIFO next state; r_q0 is always the head, empty slots held at zero.
  always_comb begin
    w_pop     = r_valid && out_ready;
    w_drop    = 1'b0;
    w_q0_nxt  = r_q0;
    w_q1_nxt  = r_q1;
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b11: begin
        if (r_cnt == 2'd2) begin
          w_q0_nxt = r_q1;
          w_q1_nxt = w_word;
        end else begin
          w_q0_nxt = w_word;
        end
      end
      2'b01: begin
        w_q0_nxt  = r_q1;
        w_q1_nxt  = '0;
        w_cnt_nxt = r_cnt - 2'd1;
      end
      2'b10: begin
        if (r_cnt == 2'd0) begin
          w_q0_nxt  = w_word;
          w_cnt_nxt = 2'd1;
        end else if (r_cnt == 2'd1) begin
          w_q1_nxt  = w_word;
          w_cnt_nxt = 2'd2;
        end else begin
          w_drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Packing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_part <= '0;
      r_fill <= 4'd0;
    end else begin
      r_part <= w_part_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  // FIFO storage, occupancy and registered valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_q0    <= w_q0_nxt;
      r_q1    <= w_q1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
    end
  end

  // Saturating MATCH counter and sticky overflow (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (sym_en && (sym_in == MATCH) && (r_hit != HIT_MAX)) begin
        r_hit <= r_hit + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign out_data  = r_q0;
  assign out_valid = r_valid;
  assign fill      = r_fill;
  assign hit_cnt   = r_hit;
  assign ovf       = r_ovf;

endmodule
